// File: rtl/alu_wb_buffer.sv
// In-order result FIFO between the ALU and the scoreboard writeback port.
// Define ALU_WB_BYPASS_EN for a 0-cycle forward path when the buffer is empty.
module alu_wb_buffer #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     alu_valid_i,
    output logic                     alu_ready_o,
    input  logic [XLEN-1:0]          alu_result_i,
    input  logic                     alu_branch_res_i,
    input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [XLEN-1:0]          wb_result_o,
    output logic                     wb_branch_res_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [CW-1:0] OneCount  = CW'(1);

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

    state_e                   r_state;
    logic [PW-1:0]            r_rd_ptr;
    logic [PW-1:0]            r_wr_ptr;
    logic [CW-1:0]            r_count;

    logic [XLEN-1:0]          r_result_mem [DEPTH];
    logic                     r_branch_mem [DEPTH];
    logic [TRANS_ID_BITS-1:0] r_tid_mem    [DEPTH];

    logic w_push;
    logic w_pop;
    logic w_wr_en;
    logic w_rd_en;
    logic w_bypass;

    assign alu_ready_o = (r_state != StFull);
    assign w_push      = alu_valid_i && alu_ready_o;
    assign w_pop       = wb_valid_o && wb_ready_i;

`ifdef ALU_WB_BYPASS_EN
    assign w_bypass = (r_state == StEmpty) && !flush_i && alu_valid_i;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed result that is accepted in the same cycle never touches storage.
    assign w_wr_en = w_push && !flush_i && !(w_bypass && wb_ready_i);
    assign w_rd_en = w_pop && (r_state != StEmpty);

    assign wb_valid_o = (r_state != StEmpty) || w_bypass;
    assign count_o    = r_count;

    always_comb begin
        wb_result_o     = r_result_mem[r_rd_ptr];
        wb_branch_res_o = r_branch_mem[r_rd_ptr];
        wb_trans_id_o   = r_tid_mem[r_rd_ptr];
        if (w_bypass) begin
            wb_result_o     = alu_result_i;
            wb_branch_res_o = alu_branch_res_i;
            wb_trans_id_o   = alu_trans_id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_result_mem[r_wr_ptr] <= alu_result_i;
            r_branch_mem[r_wr_ptr] <= alu_branch_res_i;
            r_tid_mem[r_wr_ptr]    <= alu_trans_id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= StEmpty;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_state  <= StEmpty;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_wr_en && !w_rd_en) r_count <= r_count + OneCount;
            if (w_rd_en && !w_wr_en) r_count <= r_count - OneCount;
            unique case (r_state)
                StEmpty: begin
                    if (w_wr_en) r_state <= (FullCount == OneCount) ? StFull : StPartial;
                end
                StPartial: begin
                    if (w_wr_en && !w_rd_en && r_count == FullCount - OneCount) begin
                        r_state <= StFull;
                    end else if (w_rd_en && !w_wr_en && r_count == OneCount) begin
                        r_state <= StEmpty;
                    end
                end
                StFull: begin
                    if (w_rd_en) r_state <= StPartial;
                end
                default: r_state <= StEmpty;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_wr_en && r_count == FullCount));
    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_count <= FullCount);
    a_wb_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wb_valid_o && !wb_ready_i && !flush_i) |=>
        (wb_valid_o && $stable(wb_result_o) && $stable(wb_branch_res_o)
         && $stable(wb_trans_id_o)));
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed, table-driven bench for alu_wb_buffer (DEPTH=4, registered output path).
module tb_alu_wb_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic        alu_ready_o;
    logic [63:0] alu_result_i = '0;
    logic        alu_branch_res_i = 1'b0;
    logic [2:0]  alu_trans_id_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [63:0] wb_result_o;
    logic        wb_branch_res_o;
    logic [2:0]  wb_trans_id_o;
    logic [2:0]  count_o;

    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    alu_wb_buffer #(
        .DEPTH         (4),
        .XLEN          (64),
        .TRANS_ID_BITS (3)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .alu_valid_i      (alu_valid_i),
        .alu_ready_o      (alu_ready_o),
        .alu_result_i     (alu_result_i),
        .alu_branch_res_i (alu_branch_res_i),
        .alu_trans_id_i   (alu_trans_id_i),
        .wb_valid_o       (wb_valid_o),
        .wb_ready_i       (wb_ready_i),
        .wb_result_o      (wb_result_o),
        .wb_branch_res_o  (wb_branch_res_o),
        .wb_trans_id_o    (wb_trans_id_o),
        .count_o          (count_o)
    );

    // Inputs for the cycle, then the outputs expected before that cycle's edge.
    typedef struct {
        logic        v;
        logic [63:0] res;
        logic        br;
        logic [2:0]  tid;
        logic        rdy;
        logic        fl;
        logic        ev;
        logic        er;
        logic [2:0]  ec;
        logic [2:0]  etid;
        logic [63:0] eres;
        logic        ebr;
    } vec_t;

    vec_t tv[27];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] res, input logic br,
                         input logic [2:0] tid, input logic rdy, input logic fl);
        alu_valid_i      = v;
        alu_result_i     = res;
        alu_branch_res_i = br;
        alu_trans_id_i   = tid;
        wb_ready_i       = rdy;
        flush_i          = fl;
    endtask

    logic [2:0] q[$];
    logic [2:0] next_tag;

    initial begin
        //         v  res           br tid rdy fl  ev er ec etid eres          ebr
        tv[0]  = '{1, 64'hDEADBEEF, 0, 3, 1, 0,   0, 1, 0, 0, 64'h0,        0};
        tv[1]  = '{0, 64'h0,        0, 0, 1, 0,   1, 1, 1, 3, 64'hDEADBEEF, 0};
        tv[2]  = '{0, 64'h0,        0, 0, 1, 0,   0, 1, 0, 0, 64'h0,        0};
        tv[3]  = '{1, 64'h100,      0, 0, 0, 0,   0, 1, 0, 0, 64'h0,        0};
        tv[4]  = '{1, 64'h101,      1, 1, 0, 0,   1, 1, 1, 0, 64'h100,      0};
        tv[5]  = '{1, 64'h102,      0, 2, 0, 0,   1, 1, 2, 0, 64'h100,      0};
        tv[6]  = '{1, 64'h103,      1, 3, 0, 0,   1, 1, 3, 0, 64'h100,      0};
        tv[7]  = '{1, 64'h999,      1, 4, 0, 0,   1, 0, 4, 0, 64'h100,      0};
        tv[8]  = '{0, 64'h0,        0, 0, 0, 0,   1, 0, 4, 0, 64'h100,      0};
        tv[9]  = '{1, 64'h999,      1, 4, 1, 0,   1, 0, 4, 0, 64'h100,      0};
        tv[10] = '{0, 64'h0,        0, 0, 1, 0,   1, 1, 3, 1, 64'h101,      1};
        tv[11] = '{0, 64'h0,        0, 0, 1, 0,   1, 1, 2, 2, 64'h102,      0};
        tv[12] = '{0, 64'h0,        0, 0, 1, 0,   1, 1, 1, 3, 64'h103,      1};
        tv[13] = '{0, 64'h0,        0, 0, 0, 0,   0, 1, 0, 0, 64'h0,        0};
        tv[14] = '{1, 64'h6,        0, 6, 0, 0,   0, 1, 0, 0, 64'h0,        0};
        tv[15] = '{1, 64'h7,        1, 7, 0, 0,   1, 1, 1, 6, 64'h6,        0};
        tv[16] = '{0, 64'h0,        0, 0, 1, 0,   1, 1, 2, 6, 64'h6,        0};
        tv[17] = '{0, 64'h0,        0, 0, 1, 0,   1, 1, 1, 7, 64'h7,        1};
        tv[18] = '{0, 64'h0,        0, 0, 0, 0,   0, 1, 0, 0, 64'h0,        0};
        tv[19] = '{1, 64'h11,       0, 1, 0, 0,   0, 1, 0, 0, 64'h0,        0};
        tv[20] = '{1, 64'h12,       0, 2, 0, 0,   1, 1, 1, 1, 64'h11,       0};
        tv[21] = '{1, 64'h13,       0, 3, 0, 0,   1, 1, 2, 1, 64'h11,       0};
        tv[22] = '{1, 64'h15,       1, 5, 0, 1,   1, 1, 3, 1, 64'h11,       0};
        tv[23] = '{0, 64'h0,        0, 0, 0, 0,   0, 1, 0, 0, 64'h0,        0};
        tv[24] = '{1, 64'h16,       1, 6, 0, 0,   0, 1, 0, 0, 64'h0,        0};
        tv[25] = '{0, 64'h0,        0, 0, 1, 0,   1, 1, 1, 6, 64'h16,       1};
        tv[26] = '{0, 64'h0,        0, 0, 0, 0,   0, 1, 0, 0, 64'h0,        0};

        repeat (2) @(negedge clk_i);
        chk("reset_valid", 64'(wb_valid_o), 64'd0);
        chk("reset_ready", 64'(alu_ready_o), 64'd1);
        chk("reset_count", 64'(count_o), 64'd0);
        rst_ni = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(negedge clk_i);
            drive(tv[i].v, tv[i].res, tv[i].br, tv[i].tid, tv[i].rdy, tv[i].fl);
            #1;
            chk($sformatf("v%0d_valid", i), 64'(wb_valid_o), 64'(tv[i].ev));
            chk($sformatf("v%0d_ready", i), 64'(alu_ready_o), 64'(tv[i].er));
            chk($sformatf("v%0d_count", i), 64'(count_o), 64'(tv[i].ec));
            if (tv[i].ev) begin
                chk($sformatf("v%0d_tid", i), 64'(wb_trans_id_o), 64'(tv[i].etid));
                chk($sformatf("v%0d_result", i), wb_result_o, tv[i].eres);
                chk($sformatf("v%0d_branch", i), 64'(wb_branch_res_o), 64'(tv[i].ebr));
            end
        end

        // Steady push+pop at count=2; tags wrap the pointers several times.
        next_tag = 3'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            drive(1'b1, 64'(next_tag) + 64'h200, 1'b0, next_tag, 1'b0, 1'b0);
            q.push_back(next_tag);
            next_tag = next_tag + 3'd1;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            drive(1'b1, 64'(next_tag) + 64'h200, 1'b0, next_tag, 1'b1, 1'b0);
            #1;
            chk($sformatf("pp%0d_count", i), 64'(count_o), 64'd2);
            chk($sformatf("pp%0d_tid", i), 64'(wb_trans_id_o), 64'(q[0]));
            chk($sformatf("pp%0d_result", i), wb_result_o, 64'(q[0]) + 64'h200);
            void'(q.pop_front());
            q.push_back(next_tag);
            next_tag = next_tag + 3'd1;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            drive(1'b0, 64'h0, 1'b0, 3'd0, 1'b1, 1'b0);
            #1;
            chk($sformatf("drain%0d_tid", i), 64'(wb_trans_id_o), 64'(q[0]));
            void'(q.pop_front());
        end
        @(negedge clk_i);
        drive(1'b0, 64'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        #1;
        chk("drain_empty", 64'(wb_valid_o), 64'd0);

        // Asynchronous reset with two entries held.
        @(negedge clk_i);
        drive(1'b1, 64'h22, 1'b0, 3'd2, 1'b0, 1'b0);
        @(negedge clk_i);
        drive(1'b1, 64'h33, 1'b0, 3'd3, 1'b0, 1'b0);
        @(negedge clk_i);
        drive(1'b0, 64'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        #1;
        chk("prerst_count", 64'(count_o), 64'd2);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(wb_valid_o), 64'd0);
        chk("arst_ready", 64'(alu_ready_o), 64'd1);
        chk("arst_count", 64'(count_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(1'b1, 64'h111, 1'b1, 3'd1, 1'b0, 1'b0);
        @(negedge clk_i);
        drive(1'b0, 64'h0, 1'b0, 3'd0, 1'b1, 1'b0);
        #1;
        chk("postrst_count", 64'(count_o), 64'd1);
        chk("postrst_tid", 64'(wb_trans_id_o), 64'd1);
        chk("postrst_result", wb_result_o, 64'h111);
        @(negedge clk_i);
        drive(1'b0, 64'h0, 1'b0, 3'd0, 1'b0, 1'b0);
        #1;
        chk("postrst_empty", 64'(wb_valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
